hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Stall/forward controller for the 5-stage MIPS pipeline; consumes the D-stage Tuse_rs/Tuse_rt decode.
//  Tracks dest reg + Tnew of instrs in E/M/W; asserts stall when a D operand's Tuse < producer's Tnew.
//  Drives D- and E-stage forward selects and counts stall cycles for perf debug.
// PARAMETERS
//  NOTUSE   3'd7  Tuse code meaning "operand not read"; never causes stall or forward
//  CNT_W    32    width of saturating stall-cycle counter
// PORTS
//  clk          in   1      pipeline clock, all state on rising edge
//  reset        in   1      synchronous, active-low; clears all tracking state
//  D_rs         in   5      rs field of instr in D
//  D_rt         in   5      rt field of instr in D
//  D_Tuse_rs    in   3      cycles until D instr needs rs (0=D,1=E,2=M, NOTUSE)
//  D_Tuse_rt    in   3      same for rt
//  D_wa         in   5      dest reg of instr in D (0 if no write)
//  D_Tnew       in   2      Tnew of D instr once in E: 0 jal, 1 ALU/lui/ori, 2 lw
//  stall        out  1      freeze PC+F/D regs, bubble into E (combinational)
//  D_fwd_rs     out  2      D-stage rs source: 0 GRF, 1 W, 2 M, 3 E
//  D_fwd_rt     out  2      D-stage rt source, same encoding
//  E_fwd_rs     out  2      E-stage rs source: 0 reg, 1 W, 2 M (3 unused)
//  E_fwd_rt     out  2      E-stage rt source, same encoding
//  stall_cnt    out  CNT_W  cycles with stall=1 since reset, saturating
// BEHAVIOUR
//  State: E_rs,E_rt,E_wa,E_Tnew; M_wa,M_Tnew; W_wa. Reset (reset==0 at edge): all 0, stall_cnt 0.
//  Hence after reset: stall=0, all fwd=0.
//  Advance every cycle (no enable):
//   - stall=0: E_* <= D_rs,D_rt,D_wa,D_Tnew. stall=1: E_* <= 0 (bubble).
//   - M_wa<=E_wa; M_Tnew<=(E_Tnew==0)?0:E_Tnew-1 (saturate at 0, never wrap).
//   - W_wa<=M_wa; W Tnew is implicitly 0.
//  Match(x,S) = (x!=0) && (x==S_wa). Reg $0 never matches.
//  stall = any of, for op in {rs,rt} with Tuse!=NOTUSE:
//   Match(D_op,E) && Tuse<E_Tnew  ||  Match(D_op,M) && Tuse<M_Tnew.
//   W never stalls. Compare unsigned 3-bit vs zero-extended Tnew.
//  D_fwd_op priority E>M>W (youngest wins):
//   Match(E)&&E_Tnew==0 ->3; else Match(M)&&M_Tnew==0 ->2; else Match(W) ->1; else 0.
//   A younger match with Tnew>0 blocks older: yields 0 (stall covers it).
//  E_fwd_op from E_rs/E_rt: Match(M)&&M_Tnew==0 ->2; else Match(W) ->1; else 0.
//  Fwd outputs valid even when Tuse==NOTUSE (harmless; consumer ignores).
//  stall_cnt +1 on each edge with stall=1 & reset=1; holds at all-ones.
//  Reset mid-stall: next cycle pipeline empty, stall=0, counter 0.
//  Simultaneous rs/rt hazards: single stall; D_rs==D_rt handled identically.
//  Latency: stall/fwd combinational from inputs+state, zero-cycle.
// TESTING
//  lw $1 (Tnew2) then add $3,$1,$2 -> stall=1 one cycle; then E_fwd_rs=1 (W) next cycle; stall_cnt=1.
//  lw $1 then beq $1,$2 -> stall=1 two cycles, then D_fwd_rs=1; stall_cnt=2.
//  add $1 then beq $1,$1 -> stall one cycle, then D_fwd_rs=D_fwd_rt=2 (M).
//  jal (wa=31,Tnew0) then jr $31 -> no stall, D_fwd_rs=3; lw $0 then add $4,$0,$0 -> no stall, fwd 0.
//  ori $5 then ori $5 then sw $5 (rt Tuse2) -> no stall, E_fwd_rt=2 (youngest M wins over W).
//  Force stall, drop reset low one edge -> next cycle stall=0, all fwd=0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Stall/forward controller for the 5-stage MIPS pipeline.
// Tracks producer dest/Tnew through E/M/W and derives stall, forward selects and a stall counter.
module hazard_unit #(
  parameter logic [2:0] NOTUSE = 3'd7,
  parameter int         CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [2:0]       D_Tuse_rs,
  input  logic [2:0]       D_Tuse_rt,
  input  logic [4:0]       D_wa,
  input  logic [1:0]       D_Tnew,
  output logic             stall,
  output logic [1:0]       D_fwd_rs,
  output logic [1:0]       D_fwd_rt,
  output logic [1:0]       E_fwd_rs,
  output logic [1:0]       E_fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       e_rs_reg, e_rt_reg, e_wa_reg;
  logic [1:0]       e_tnew_reg;
  logic [4:0]       m_wa_reg;
  logic [1:0]       m_tnew_reg;
  logic [4:0]       w_wa_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // Register $0 is hard-wired, so it never produces a dependency.
  function automatic logic hit(input logic [4:0] x, input logic [4:0] s);
    return (x != 5'd0) && (x == s);
  endfunction

  logic [4:0] d_op   [2];
  logic [2:0] d_tuse [2];
  logic [4:0] e_op   [2];
  logic       hazard [2];
  logic [1:0] d_fwd  [2];
  logic [1:0] e_fwd  [2];

  assign d_op[0]   = D_rs;
  assign d_op[1]   = D_rt;
  assign d_tuse[0] = D_Tuse_rs;
  assign d_tuse[1] = D_Tuse_rt;
  assign e_op[0]   = e_rs_reg;
  assign e_op[1]   = e_rt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      always_comb begin
        hazard[gi] = 1'b0;
        if (d_tuse[gi] != NOTUSE) begin
          hazard[gi] = (hit(d_op[gi], e_wa_reg) && (d_tuse[gi] < {1'b0, e_tnew_reg})) ||
                       (hit(d_op[gi], m_wa_reg) && (d_tuse[gi] < {1'b0, m_tnew_reg}));
        end
      end

      // Youngest matching producer decides; one still computing yields 0 (stall covers it).
      always_comb begin
        d_fwd[gi] = 2'd0;
        if (hit(d_op[gi], e_wa_reg))
          d_fwd[gi] = (e_tnew_reg == 2'd0) ? 2'd3 : 2'd0;
        else if (hit(d_op[gi], m_wa_reg))
          d_fwd[gi] = (m_tnew_reg == 2'd0) ? 2'd2 : 2'd0;
        else if (hit(d_op[gi], w_wa_reg))
          d_fwd[gi] = 2'd1;
      end

      always_comb begin
        e_fwd[gi] = 2'd0;
        if (hit(e_op[gi], m_wa_reg) && (m_tnew_reg == 2'd0))
          e_fwd[gi] = 2'd2;
        else if (hit(e_op[gi], w_wa_reg))
          e_fwd[gi] = 2'd1;
      end
    end
  endgenerate

  assign stall     = hazard[0] | hazard[1];
  assign D_fwd_rs  = d_fwd[0];
  assign D_fwd_rt  = d_fwd[1];
  assign E_fwd_rs  = e_fwd[0];
  assign E_fwd_rt  = e_fwd[1];
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rs_reg      <= 5'd0;
      e_rt_reg      <= 5'd0;
      e_wa_reg      <= 5'd0;
      e_tnew_reg    <= 2'd0;
      m_wa_reg      <= 5'd0;
      m_tnew_reg    <= 2'd0;
      w_wa_reg      <= 5'd0;
      stall_cnt_reg <= '0;
    end else begin
      if (stall) begin
        e_rs_reg   <= 5'd0;
        e_rt_reg   <= 5'd0;
        e_wa_reg   <= 5'd0;
        e_tnew_reg <= 2'd0;
      end else begin
        e_rs_reg   <= D_rs;
        e_rt_reg   <= D_rt;
        e_wa_reg   <= D_wa;
        e_tnew_reg <= D_Tnew;
      end
      m_wa_reg   <= e_wa_reg;
      m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
      w_wa_reg   <= m_wa_reg;
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction pairs from the MIPS pipeline with hand-derived results.
// A narrow stall counter lets the saturation boundary be reached quickly.
module tb_hazard_unit;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       D_rs, D_rt, D_wa;
  logic [2:0]       D_Tuse_rs, D_Tuse_rt;
  logic [1:0]       D_Tnew;
  logic             stall;
  logic [1:0]       D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  hazard_unit #(.NOTUSE(3'd7), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_wa(D_wa), .D_Tnew(D_Tnew),
    .stall(stall), .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt),
    .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] urs,
                       input logic [2:0] urt, input logic [4:0] wa, input logic [1:0] tnew);
    D_rs = rs; D_rt = rt; D_Tuse_rs = urs; D_Tuse_rt = urt; D_wa = wa; D_Tnew = tnew;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 2'd0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    nop();
    tick();
    do_reset();

    // Reset state
    chk("rst_stall", stall, 0);
    chk("rst_dfwd_rs", D_fwd_rs, 0);
    chk("rst_dfwd_rt", D_fwd_rt, 0);
    chk("rst_efwd_rs", E_fwd_rs, 0);
    chk("rst_cnt", stall_cnt, 0);

    // lw $1 ; add $3,$1,$2
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd1, 2'd2);
    chk("lw_add_nostall0", stall, 0);
    tick();
    set_d(5'd1, 5'd2, 3'd1, 3'd1, 5'd3, 2'd1);
    chk("lw_add_stall", stall, 1);
    tick();
    chk("lw_add_release", stall, 0);
    chk("lw_add_dfwd_blk", D_fwd_rs, 0);
    tick();
    nop();
    chk("lw_add_efwd_rs", E_fwd_rs, 1);
    chk("lw_add_efwd_rt", E_fwd_rt, 0);
    chk("lw_add_cnt", stall_cnt, 1);

    // lw $1 ; beq $1,$2
    do_reset();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd1, 2'd2);
    tick();
    set_d(5'd1, 5'd2, 3'd0, 3'd0, 5'd0, 2'd0);
    chk("lw_beq_stall1", stall, 1);
    tick();
    chk("lw_beq_stall2", stall, 1);
    tick();
    chk("lw_beq_release", stall, 0);
    chk("lw_beq_dfwd_rs", D_fwd_rs, 1);
    chk("lw_beq_dfwd_rt", D_fwd_rt, 0);
    chk("lw_beq_cnt", stall_cnt, 2);

    // add $1 ; beq $1,$1 (both operands hazard, one stall)
    do_reset();
    set_d(5'd2, 5'd3, 3'd1, 3'd1, 5'd1, 2'd1);
    tick();
    set_d(5'd1, 5'd1, 3'd0, 3'd0, 5'd0, 2'd0);
    chk("add_beq_stall", stall, 1);
    tick();
    chk("add_beq_release", stall, 0);
    chk("add_beq_dfwd_rs", D_fwd_rs, 2);
    chk("add_beq_dfwd_rt", D_fwd_rt, 2);
    chk("add_beq_cnt", stall_cnt, 1);

    // jal ; jr $31 ; lw $0 ; add $4,$0,$0 ; lw $1 ; NOTUSE reader of $1
    do_reset();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd31, 2'd0);
    tick();
    set_d(5'd31, 5'd0, 3'd0, 3'd7, 5'd0, 2'd0);
    chk("jal_jr_stall", stall, 0);
    chk("jal_jr_dfwd_rs", D_fwd_rs, 3);
    tick();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd0, 2'd2);
    tick();
    set_d(5'd0, 5'd0, 3'd1, 3'd1, 5'd4, 2'd1);
    chk("r0_stall", stall, 0);
    chk("r0_dfwd_rs", D_fwd_rs, 0);
    chk("r0_dfwd_rt", D_fwd_rt, 0);
    tick();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd1, 2'd2);
    tick();
    set_d(5'd1, 5'd1, 3'd7, 3'd7, 5'd0, 2'd0);
    chk("notuse_stall", stall, 0);
    chk("notuse_dfwd_blk", D_fwd_rs, 0);
    chk("notuse_cnt", stall_cnt, 0);

    // ori $5 ; ori $5 ; sw $5
    do_reset();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd5, 2'd1);
    tick();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd5, 2'd1);
    chk("ori_ori_stall", stall, 0);
    tick();
    set_d(5'd0, 5'd5, 3'd1, 3'd2, 5'd0, 2'd0);
    chk("sw_stall", stall, 0);
    chk("sw_dfwd_rt_blk", D_fwd_rt, 0);
    tick();
    nop();
    chk("sw_efwd_rt", E_fwd_rt, 2);
    chk("sw_efwd_rs", E_fwd_rs, 0);

    // Reset asserted during a stall
    do_reset();
    set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd1, 2'd2);
    tick();
    set_d(5'd1, 5'd2, 3'd1, 3'd1, 5'd3, 2'd1);
    chk("midrst_stall_before", stall, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_dfwd_rs", D_fwd_rs, 0);
    chk("midrst_dfwd_rt", D_fwd_rt, 0);
    chk("midrst_efwd_rs", E_fwd_rs, 0);
    chk("midrst_cnt", stall_cnt, 0);

    // Counter saturation: each lw/beq pair adds two stall cycles
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_d(5'd0, 5'd0, 3'd1, 3'd7, 5'd1, 2'd2);
      tick();
      set_d(5'd1, 5'd2, 3'd0, 3'd0, 5'd0, 2'd0);
      tick();
      tick();
      tick();
      if (i == 6) chk("sat_cnt14", stall_cnt, 14);
      if (i == 7) chk("sat_cnt15", stall_cnt, 15);
    end
    chk("sat_hold", stall_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
